// File: rtl/quadrature_pkg.sv
// Shared encodings and defaults for the quadrature decoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package quadrature_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_FILT_LEN = 2;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Filtered phase state, encoded {A,B}.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } phase_t;

  // Successor of a phase state in forward motion (00 -> 10 -> 11 -> 01 -> 00).
  function automatic phase_t fwd_next(input phase_t s);
    phase_t n;
    n = S00;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      default: n = S00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer plus stability filter for one quadrature channel.
// Latency: edge sampled at clock k appears on filt_o after edge k+1+FILT_LEN.
// Backpressure: none; free-running, shorter-than-FILT_LEN pulses are dropped.
//
// Ports:
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   din_i         : raw channel input, asynchronous to clk_i
//   filt_o        : accepted (filtered) level
//   vld_o         : high once the first level has been accepted since reset
module quad_sync_filter
  import quadrature_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic din_i,
  output logic filt_o,
  output logic vld_o
);

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  logic       sync1_q, sync2_q;
  logic [1:0] fill_q;            // tracks which sync stages hold a real sample
  logic [3:0] run_q, run_d;      // consecutive cycles sync2_q has held its value
  logic       filt_q, filt_d;
  logic       vld_q, vld_d;

  always_comb begin
    run_d  = run_q;
    filt_d = filt_q;
    vld_d  = vld_q;

    // Reset values in the synchronizer are not samples; do not let them
    // count towards stability or the first accepted level could be bogus.
    if (!fill_q[0]) begin
      run_d = '0;
    end else if (!fill_q[1] || (sync1_q != sync2_q)) begin
      run_d = 4'd1;
    end else if (run_q != 4'hF) begin
      run_d = run_q + 4'd1;
    end

    if (run_q >= FILT_LEN_C) begin
      filt_d = sync2_q;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= '0;
      run_q   <= '0;
      filt_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      run_q   <= run_d;
      filt_q  <= filt_d;
      vld_q   <= vld_d;
    end
  end

  assign filt_o = filt_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: filtered A/B phases drive a signed wrapping position counter.
// Latency: edge sampled at clock k updates count/dir/step at edge k+2+FILT_LEN.
// Backpressure: none; at most one count update per cycle.
//
// Ports:
//   clk, nrst      : clock, asynchronous active-low reset
//   phs_0, phs_90  : channel A / channel B, asynchronous to clk
//   clr            : synchronous clear of count and err
//   count          : signed two's-complement position (CNT_W bits)
//   dir            : 1 = last valid step forward, 0 = reverse
//   step           : one-cycle pulse per valid count update
//   err            : sticky illegal-transition flag
// Build option: QUAD_ERR_DETECT_EN enables err; otherwise err is tied low.
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             phs_0,
  input  logic             phs_90,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic a_filt, a_vld, b_filt, b_vld;

  quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_i  (clk),
    .nrst_i (nrst),
    .din_i  (phs_0),
    .filt_o (a_filt),
    .vld_o  (a_vld)
  );

  quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_i  (clk),
    .nrst_i (nrst),
    .din_i  (phs_90),
    .filt_o (b_filt),
    .vld_o  (b_vld)
  );

  phase_t           cur;
  phase_t           state_q, state_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             is_fwd, is_rev;
`ifdef QUAD_ERR_DETECT_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    cur      = phase_t'({a_filt, b_filt});
    is_fwd   = (cur == fwd_next(state_q));
    is_rev   = (state_q == fwd_next(cur));
    state_d  = state_q;
    primed_d = primed_q;
    count_d  = count_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
`ifdef QUAD_ERR_DETECT_EN
    err_d    = err_q;
`endif

    if (!primed_q) begin
      // First accepted level only seeds the state register.
      if (a_vld && b_vld) begin
        state_d  = cur;
        primed_d = 1'b1;
      end
    end else if (cur != state_q) begin
      state_d = cur;   // always resync, even across an illegal jump
      if (is_fwd) begin
        count_d = count_q + CNT_W'(1);
        dir_d   = DIR_FWD;
        step_d  = 1'b1;
      end else if (is_rev) begin
        count_d = count_q - CNT_W'(1);
        dir_d   = DIR_REV;
        step_d  = 1'b1;
      end else begin
`ifdef QUAD_ERR_DETECT_EN
        err_d = 1'b1;
`endif
      end
    end

    // clr overrides the count (and err) but leaves step/dir of a coincident step.
    if (clr) begin
      count_d = '0;
`ifdef QUAD_ERR_DETECT_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S00;
      primed_q <= 1'b0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
    end
  end

`ifdef QUAD_ERR_DETECT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder (16-bit main instance plus a
// 4-bit instance sharing the same inputs to exercise counter wrap cheaply).
// Step events are predicted at drive time and matched by a negedge monitor.
module tb_quadrature_decoder;

`ifdef QUAD_ERR_DETECT_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        nrst;
  logic        phs_0;
  logic        phs_90;
  logic        clr;
  logic [15:0] count;
  logic        dir, step, err;
  logic [3:0]  count_n;
  logic        dir_n, step_n, err_n;

  quadrature_decoder #(.CNT_W(16), .FILT_LEN(2)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .phs_0  (phs_0),
    .phs_90 (phs_90),
    .clr    (clr),
    .count  (count),
    .dir    (dir),
    .step   (step),
    .err    (err)
  );

  quadrature_decoder #(.CNT_W(4), .FILT_LEN(2)) dut_n (
    .clk    (clk),
    .nrst   (nrst),
    .phs_0  (phs_0),
    .phs_90 (phs_90),
    .clr    (clr),
    .count  (count_n),
    .dir    (dir_n),
    .step   (step_n),
    .err    (err_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        dir;
  } exp_t;

  typedef struct {
    logic [1:0]  ab;
    logic [15:0] cnt;
    logic        dir;
  } vec_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   steps_seen = 0;
  int   steps_n    = 0;
  logic prev_step  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every step pulse must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_step: no step by cycle %0d expected at %0d", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      if (step_n) steps_n++;
      if (step) begin
        steps_seen++;
        checks++;
        if (prev_step) begin
          errors++;
          $display("FAIL step_back2back: step high in consecutive cycles at %0d", cyc);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_step: unexpected step at cycle %0d count %0h", cyc, count);
        end else begin
          e = sb_q.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_count", count, e.cnt);
          chk("step_dir", dir, e.dir);
        end
      end
      prev_step = step;
    end else begin
      prev_step = 1'b0;
    end
  end

  task automatic drive_ab(input logic [1:0] ab, input bit exp_step,
                          input logic [15:0] ecnt, input logic edir, input int hold);
    exp_t e;
    @(negedge clk);
    {phs_0, phs_90} = ab;
    if (exp_step) begin
      e.cyc = cyc + 5;   // sampled at edge cyc+1, visible after edge cyc+1+2+FILT_LEN
      e.cnt = ecnt;
      e.dir = edir;
      sb_q.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [1:0]  fseq [4];
  int          fidx;
  logic [15:0] mdl_cnt;
  vec_t        tbl [14];

  // Quadrature emulator: n steps in one direction from the modelled position.
  task automatic quad_emu(input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      if (fwd) begin
        fidx    = (fidx + 1) % 4;
        mdl_cnt = mdl_cnt + 16'd1;
      end else begin
        fidx    = (fidx + 3) % 4;
        mdl_cnt = mdl_cnt - 16'd1;
      end
      drive_ab(fseq[fidx], 1'b1, mdl_cnt, fwd, 4);
    end
  endtask

  initial begin
    int c0;
    int base;
    exp_t e;

    fseq[0] = 2'b00; fseq[1] = 2'b10; fseq[2] = 2'b11; fseq[3] = 2'b01;
    // Reverse run from 0 with a forward/reverse wiggle; ends at -12.
    tbl[0]  = '{2'b01, 16'hFFFF, 1'b0};
    tbl[1]  = '{2'b11, 16'hFFFE, 1'b0};
    tbl[2]  = '{2'b10, 16'hFFFD, 1'b0};
    tbl[3]  = '{2'b00, 16'hFFFC, 1'b0};
    tbl[4]  = '{2'b10, 16'hFFFD, 1'b1};
    tbl[5]  = '{2'b00, 16'hFFFC, 1'b0};
    tbl[6]  = '{2'b01, 16'hFFFB, 1'b0};
    tbl[7]  = '{2'b11, 16'hFFFA, 1'b0};
    tbl[8]  = '{2'b10, 16'hFFF9, 1'b0};
    tbl[9]  = '{2'b00, 16'hFFF8, 1'b0};
    tbl[10] = '{2'b01, 16'hFFF7, 1'b0};
    tbl[11] = '{2'b11, 16'hFFF6, 1'b0};
    tbl[12] = '{2'b10, 16'hFFF5, 1'b0};
    tbl[13] = '{2'b00, 16'hFFF4, 1'b0};

    nrst = 1'b0; phs_0 = 1'b0; phs_90 = 1'b0; clr = 1'b0;
    fidx = 0; mdl_cnt = 16'd0;

    // Reset state
    #3;
    chk("rst_count", count, 16'd0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_err", err, 1'b0);
    settle(2);
    nrst = 1'b1;
    settle(10);
    chk("prime_count", count, 16'd0);

    // 10 full forward cycles
    base = steps_seen;
    quad_emu(40, 1'b1);
    settle(8);
    chk("fwd40_count", count, 16'd40);
    chk("fwd40_dir", dir, 1'b1);
    chk("fwd40_err", err, 1'b0);
    chk("fwd40_steps", steps_seen - base, 40);
    chk("narrow_wrap_up", count_n, 4'h8);

    pulse_clr();
    chk("clr_count", count, 16'd0);

    // Table-driven reverse sequence
    for (int i = 0; i < 14; i++) drive_ab(tbl[i].ab, 1'b1, tbl[i].cnt, tbl[i].dir, 4);
    settle(8);
    chk("rev_count", count, 16'hFFF4);
    chk("rev_dir", dir, 1'b0);
    chk("narrow_wrap_down", count_n, 4'h4);

    // One-cycle glitch on A must be ignored
    @(negedge clk); phs_0 = 1'b1;
    @(negedge clk); phs_0 = 1'b0;
    settle(12);
    chk("glitch_count", count, 16'hFFF4);

    // Single clean edge: step exactly at predicted cycle (checked by monitor)
    drive_ab(2'b10, 1'b1, 16'hFFF5, 1'b1, 8);
    chk("edge_count", count, 16'hFFF5);
    drive_ab(2'b00, 1'b1, 16'hFFF4, 1'b0, 8);

    // Illegal jump 00 -> 11
    drive_ab(2'b11, 1'b0, 16'h0, 1'b0, 10);
    chk("illegal_count", count, 16'hFFF4);
    chk("illegal_dir", dir, 1'b0);
    chk("illegal_err", err, ERR_EN);
    chk("illegal_err_n", err_n, ERR_EN);
    pulse_clr();
    chk("clr2_count", count, 16'd0);
    chk("clr2_err", err, 1'b0);

    // State resynced to 11: next forward edge counts
    drive_ab(2'b01, 1'b1, 16'd1, 1'b1, 4);
    drive_ab(2'b00, 1'b1, 16'd2, 1'b1, 4);
    drive_ab(2'b10, 1'b1, 16'd3, 1'b1, 4);
    drive_ab(2'b11, 1'b1, 16'd4, 1'b1, 8);
    chk("pre_rst_count", count, 16'd4);

    // Reset with inputs held at 11: immediate clear, then priming without a step
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_count", count, 16'd0);
    chk("arst_dir", dir, 1'b0);
    settle(3);
    nrst = 1'b1;
    settle(15);
    chk("reprime_count", count, 16'd0);
    drive_ab(2'b01, 1'b1, 16'd1, 1'b1, 8);
    chk("reprime_step_count", count, 16'd1);

    // clr lands on the same edge as a forward step
    @(negedge clk);
    {phs_0, phs_90} = 2'b00;
    c0 = cyc;
    e.cyc = c0 + 5; e.cnt = 16'd0; e.dir = 1'b1;
    sb_q.push_back(e);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_step_pulse", step, 1'b1);
    chk("clr_step_count", count, 16'd0);
    chk("clr_step_dir", dir, 1'b1);

    settle(10);
    chk("sb_empty", sb_q.size(), 0);
    chk("narrow_steps", steps_n, steps_seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
